// File: rtl/fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_req_ctrl
//  Description : Instruction-fetch request sequencer. Issues one imem read at
//                a time, buffers returned words with their PC in a small
//                FIFO for decode, and on a backend redirect retargets the
//                fetch PC, flushes the FIFO and drops the stale response.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_req_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h1eceb000,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          imem_addr,
    output logic [3:0]           imem_rmask,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_resp,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr,
    output logic [31:0]          instr_pc,
    output logic [CNT_WIDTH-1:0] discard_count,
    output logic                 busy
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_issue   = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_discard = 2'd2;

    logic [1:0]           r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_req_addr;
    logic [31:0]          r_fifo_instr [FIFO_DEPTH];
    logic [31:0]          r_fifo_pc    [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic [CNT_WIDTH-1:0] r_discard;

    logic w_fifo_empty;
    logic w_has_space;
    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Space is judged on the registered count, so a slot is reserved for the
    // single outstanding request and a push can never find the FIFO full.
    assign w_fifo_empty = (r_count == '0);
    assign w_has_space  = (r_count < c_depth);
    assign w_issue      = (r_state == c_st_issue) && !redirect && w_has_space;
    assign w_push       = (r_state == c_st_wait) && imem_resp && !redirect;
    // A redirect flushes the FIFO, so a same-cycle pop is meaningless.
    assign w_pop        = !w_fifo_empty && instr_ready && !redirect;
    assign w_drop       = imem_resp &&
                          (((r_state == c_st_wait) && redirect) || (r_state == c_st_discard));

    // While a request is outstanding the address is held from the issue
    // cycle; in DISCARD pc is already retargeted but the memory still
    // expects the stale address until it answers.
    assign imem_addr     = (r_state == c_st_issue) ? r_pc : r_req_addr;
    assign imem_rmask    = (w_issue && !rst) ? 4'hf : 4'h0;
    assign busy          = (r_state != c_st_issue);
    assign instr_valid   = !w_fifo_empty;
    assign instr         = w_fifo_empty ? 32'h0 : r_fifo_instr[r_rd_ptr];
    assign instr_pc      = w_fifo_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
    assign discard_count = r_discard;

    // Request sequencer: issue, wait for the response, or discard a stale one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_issue;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            case (r_state)
                c_st_issue: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else if (w_has_space) begin
                        r_req_addr <= r_pc;
                        r_state    <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= imem_resp ? c_st_issue : c_st_discard;
                    end else if (imem_resp) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= c_st_issue;
                    end
                end
                c_st_discard: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem_resp) begin
                        r_state <= c_st_issue;
                    end
                end
                default: r_state <= c_st_issue;
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; head outputs are masked when empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_pc;
        end
    end

    // Saturating count of responses dropped because of a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard <= '0;
        end else if (w_drop && (r_discard != '1)) begin
            r_discard <= r_discard + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_req_ctrl
//  Description : Scoreboard bench for fetch_req_ctrl with a variable-latency
//                memory model; memory word at address A is ~A.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_req_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;
    localparam int          CW       = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [31:0]   imem_addr;
    logic [3:0]    imem_rmask;
    logic [31:0]   imem_rdata;
    logic          imem_resp;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic [CW-1:0] discard_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int mem_lat = 1;
    bit mem_survive = 1'b0;
    int mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    logic [63:0] exp_q[$];
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    int          pop_cyc_q[$];

    fetch_req_ctrl #(
        .FIFO_DEPTH (4),
        .RESET_PC   (RESET_PC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rmask    (imem_rmask),
        .imem_rdata    (imem_rdata),
        .imem_resp     (imem_resp),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .discard_count (discard_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] req_a(input int i);
        return (i < req_addr_q.size()) ? req_addr_q[i] : 32'hxxxxxxxx;
    endfunction

    function automatic int req_c(input int i);
        return (i < req_cyc_q.size()) ? req_cyc_q[i] : -1000;
    endfunction

    function automatic int pop_c(input int i);
        return (i < pop_cyc_q.size()) ? pop_cyc_q[i] : -1000;
    endfunction

    // Memory model: answers each request after mem_lat cycles with ~addr.
    initial begin
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp  = 1'b0;
            imem_rdata = 32'h0;
            if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = ~mem_addr;
                end
            end
            @(negedge clk);
            if (rst && !mem_survive) begin
                mem_cnt = 0;
            end else if (imem_rmask == 4'hf) begin
                mem_addr = imem_addr;
                mem_cnt  = mem_lat;
            end
        end
    end

    // Monitor: logs requests and checks every accepted FIFO head.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (imem_rmask == 4'hf) begin
                req_addr_q.push_back(imem_addr);
                req_cyc_q.push_back(cyc);
            end
            if (instr_valid && instr_ready) begin
                pop_cyc_q.push_back(cyc);
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc=%h instr=%h, required no instruction",
                             instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    check("head_pc", instr_pc, e[63:32]);
                    check("head_instr", instr, e[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_rmask", {28'h0, imem_rmask}, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_discard", 32'(discard_count), 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        exp_q.delete();
        req_addr_q.delete();
        req_cyc_q.delete();
        pop_cyc_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int n);
        int k = 0;
        while (req_addr_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (req_addr_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got %0d requests, required %0d", req_addr_q.size(), n);
        end
    endtask

    // Expect n sequential instructions from base, consume them, then stall.
    task automatic consume(input int n, input logic [31:0] base);
        int k = 0;
        int target;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            exp_q.push_back({a, ~a});
        end
        target = pop_cnt + n;
        instr_ready = 1'b1;
        while (pop_cnt < target && k < 300) begin
            tick();
            k++;
        end
        instr_ready = 1'b0;
        check("consume_count", 32'(pop_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        // 1: back-to-back fetch with one-cycle memory, consumer always ready
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        consume(3, RESET_PC);
        check("t1_addr0", req_a(0), RESET_PC);
        check("t1_addr1", req_a(1), RESET_PC + 32'd4);
        check("t1_addr2", req_a(2), RESET_PC + 32'd8);
        check("t1_gap1", 32'(req_c(1) - req_c(0)), 32'd2);
        check("t1_gap2", 32'(req_c(2) - req_c(0)), 32'd4);
        check("t1_valid_lat", 32'(pop_c(0) - req_c(0)), 32'd2);
        check("t1_discard", 32'(discard_count), 32'd0);

        // 2: stalled consumer fills the FIFO, then drains
        do_reset();
        repeat (20) tick();
        check("t2_req_count", 32'(req_addr_q.size()), 32'd4);
        check("t2_addr3", req_a(3), RESET_PC + 32'd12);
        @(negedge clk);
        check("t2_valid", {31'h0, instr_valid}, 32'h1);
        check("t2_head_pc", instr_pc, RESET_PC);
        check("t2_head_instr", instr, ~RESET_PC);
        tick();
        consume(4, RESET_PC);
        check("t2_addr4", req_a(4), RESET_PC + 32'd16);
        check("t2_refill_lat", 32'(req_c(4) - pop_c(0)), 32'd1);

        // 3: redirect while waiting on a slow response
        mem_lat = 5;
        do_reset();
        wait_req(1);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h1eceb100;
        tick();
        redirect = 1'b0;
        wait_req(2);
        check("t3_addr", req_a(1), 32'h1eceb100);
        check("t3_gap", 32'(req_c(1) - req_c(0)), 32'd6);
        check("t3_discard", 32'(discard_count), 32'd1);
        consume(2, 32'h1eceb100);

        // 4: redirect coincides with the response
        mem_lat = 3;
        do_reset();
        wait_req(1);
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h00001000;
        tick();
        redirect = 1'b0;
        wait_req(2);
        check("t4_addr", req_a(1), 32'h00001000);
        check("t4_gap", 32'(req_c(1) - req_c(0)), 32'd4);
        check("t4_discard", 32'(discard_count), 32'd1);
        consume(1, 32'h00001000);

        // 5: two redirects while discarding; the latest target wins
        mem_lat = 6;
        do_reset();
        wait_req(1);
        redirect = 1'b1;
        redirect_pc = 32'h00000100;
        tick();
        redirect = 1'b0;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h00000200;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("t5_stale_addr", imem_addr, RESET_PC);
        check("t5_busy", {31'h0, busy}, 32'h1);
        check("t5_rmask", {28'h0, imem_rmask}, 32'h0);
        wait_req(2);
        check("t5_addr", req_a(1), 32'h00000200);
        check("t5_gap", 32'(req_c(1) - req_c(0)), 32'd7);
        check("t5_discard", 32'(discard_count), 32'd1);
        consume(1, 32'h00000200);

        // 6: reset mid-wait; the abandoned response lands in the ISSUE cycle
        mem_lat = 2;
        mem_survive = 1'b1;
        do_reset();
        wait_req(1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_rmask", {28'h0, imem_rmask}, 32'h0);
        check("t6_rst_addr", imem_addr, RESET_PC);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_reissue", {28'h0, imem_rmask}, 32'hf);
        tick();
        wait_req(2);
        check("t6_addr", req_a(1), RESET_PC);
        check("t6_gap", 32'(req_c(1) - req_c(0)), 32'd2);
        consume(2, RESET_PC);
        check("t6_discard", 32'(discard_count), 32'd0);
        mem_survive = 1'b0;

        // 7: discard counter saturates (2-bit instance)
        mem_lat = 1;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            wait_req(k);
            redirect = 1'b1;
            redirect_pc = 32'h00000300;
            tick();
            redirect = 1'b0;
            check("t7_discard", 32'(discard_count), (k < 3) ? 32'(k) : 32'd3);
        end
        check("t7_addr", req_a(1), 32'h00000300);

        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
